div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle signed 32-bit integer divider for the ALU's mult/div path. It is the inverse-operation companion to the multiplier.
- Uses a serial restoring algorithm, one quotient bit per cycle.
- Operands are converted to magnitude form with bitwise-NOT-plus-one. Signs are reapplied on completion.
- Drives quotient, remainder, exception and a one-cycle ready pulse back to the pipeline's mult/div stall logic.

Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- ctrl_div  input  1  start pulse; operands are sampled on the edge where it is high.
- data_operandA  input  WIDTH  dividend, two's complement.
- data_operandB  input  WIDTH  divisor, two's complement.
- data_result  output  WIDTH  quotient, two's complement.
- data_remainder  output  WIDTH  remainder; its sign follows the dividend.
- data_exception  output  1  divide-by-zero or overflow.
- data_resultRDY  output  1  high for exactly one cycle when outputs are valid.
- busy  output  1  high while IDLE is not the current state.

Behaviour:
- Reset and clocking: one clock; reset is asynchronous and active-high, ports named clock and reset. While reset is asserted, the state is IDLE and all outputs are 0.
- States:
  - IDLE: waiting for a start.
  - RUN: iterating, with a 6-bit counter cnt.
  - DONE: results presented.
- IDLE, ctrl_div=1 on edge N:
  - Latch signA and signB.
  - Latch |A| and |B|, computed as (~x)+1 when negative.
  - Clear the remainder accumulator R (WIDTH+1 bits). Set Q = |A|. Set cnt = 0.
  - If B==0 or (A==0x80000000 and B==0xFFFFFFFF), go to DONE with the exception flag set. Otherwise go to RUN.
- RUN, each edge:
  - Shift {R,Q} left by 1.
  - Compute T = R − |B|.
  - If T is non-negative, set R = T and Q[0] = 1. Otherwise set Q[0] = 0.
  - Increment cnt. When the WIDTH-th iteration completes (cnt reaches WIDTH), go to DONE.
- DONE, for one cycle:
  - data_resultRDY = 1.
  - data_result = negated Q if signA^signB, else Q.
  - data_remainder = negated R if signA, else R.
  - Next edge returns to IDLE.
- Latency: the ready pulse is high in the cycle following edge N+WIDTH (N+32). For exceptions it is high in the cycle following edge N+1.
- Exception results:
  - Divide-by-zero: data_exception=1, quotient=0, remainder=0.
  - Overflow: data_exception=1, quotient=0x80000000, remainder=0.
- Outputs hold their values after DONE until the next accepted start. data_resultRDY and data_exception drop to 0 on the next start.
- ctrl_div asserted during RUN or DONE aborts the current operation and restarts with the new operands, exactly as from IDLE. The aborted operation produces no ready pulse.
- Reset asserted mid-RUN returns to IDLE immediately. No ready pulse is produced.
- Dividend 0 with a nonzero divisor is normal: after the full latency, quotient=0 and remainder=0.

Decomposition:
- Shared package holds:
  - WIDTH default.
  - State encodings IDLE/RUN/DONE as 2-bit constants.
  - INT_MIN constant (0x80000000).
  - Iteration-count width.
- One sub-module: twos_negate. It is combinational: WIDTH-bit NOT plus increment, built from the existing bitwise NOT and adder cells. It is instantiated three times: operand magnitudes, quotient fix-up and remainder fix-up (shared where possible).

Test Plan:
- A=100, B=7, ctrl_div pulse -> ready after 32 edges; result=14, remainder=2, exception=0; busy high throughout.
- A=−100 (0xFFFFFF9C), B=7 -> result=0xFFFFFFF2 (−14), remainder=0xFFFFFFFE (−2). A=100, B=−7 -> result=−14, remainder=2.
- A=5, B=0 -> ready one cycle after start; exception=1, result=0, remainder=0. A=0x80000000, B=0xFFFFFFFF -> exception=1, result=0x80000000.
- Start A=100, B=7; at cycle 10 pulse ctrl_div with A=45, B=9 -> no ready for the first operation; ready 32 edges after the second start; result=5, remainder=0.
- Assert reset asynchronously at cycle 15 of a run -> outputs 0 and busy 0 immediately; no ready pulse. A fresh start after release computes correctly.
- Random signed pairs, B≠0, excluding the overflow pair -> result*B + remainder == A, |remainder| < |B|, and the remainder sign matches A (or remainder is 0).

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the serial signed divider: widths, state encodings
// and the most-negative operand value.
package div_unit_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int CNT_W     = 6;

   localparam logic [DIV_WIDTH-1:0] INT_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_unit_twos_negate.sv
// Combinational two's complement negation: bitwise NOT followed by increment.
module div_unit_twos_negate #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y
);

   logic [WIDTH-1:0] inv_s;

   assign inv_s = ~x;
   assign y     = inv_s + {{(WIDTH-1){1'b0}}, 1'b1};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed divider: restoring algorithm on magnitudes, one quotient
// bit per clock, signs reapplied when the last bit is produced.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_div,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic [WIDTH-1:0] data_remainder,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam logic [WIDTH-1:0] MIN_NEG   = INT_MIN[DIV_WIDTH-1 -: WIDTH];
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sign_a_q, sign_a_d;
   logic             sign_b_q, sign_b_d;
   logic [WIDTH-1:0] mag_b_q, mag_b_d;
   // R stays below |B| after each step, so its always-zero top bit is not stored.
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             exc_q, exc_d;
   logic             rdy_q, rdy_d;

   logic [WIDTH:0]   shifted_s;
   logic [WIDTH:0]   trial_s;
   logic [WIDTH-1:0] r_nx_s, q_nx_s;
   logic [WIDTH-1:0] neg_a_in_s, neg_a_s, neg_b_s, neg_r_s;
   logic [WIDTH-1:0] mag_a_s, mag_b_s;
   logic             div_zero_s, ovf_s;

   // Operand A and the final quotient never need negating in the same cycle.
   assign neg_a_in_s = ctrl_div ? data_operandA : q_nx_s;

   div_unit_twos_negate #(.WIDTH(WIDTH)) u_neg_aq (.x(neg_a_in_s),    .y(neg_a_s));
   div_unit_twos_negate #(.WIDTH(WIDTH)) u_neg_b  (.x(data_operandB), .y(neg_b_s));
   div_unit_twos_negate #(.WIDTH(WIDTH)) u_neg_r  (.x(r_nx_s),        .y(neg_r_s));

   assign mag_a_s    = data_operandA[WIDTH-1] ? neg_a_s : data_operandA;
   assign mag_b_s    = data_operandB[WIDTH-1] ? neg_b_s : data_operandB;
   assign div_zero_s = (data_operandB == {WIDTH{1'b0}});
   assign ovf_s      = (data_operandA == MIN_NEG) && (data_operandB == {WIDTH{1'b1}});

   // One restoring step: shift {R,Q}, trial-subtract |B|, keep or restore.
   always_comb begin
      shifted_s = {r_q, q_q[WIDTH-1]};
      trial_s   = shifted_s - {1'b0, mag_b_q};
      if (!trial_s[WIDTH]) begin
         r_nx_s = trial_s[WIDTH-1:0];
         q_nx_s = {q_q[WIDTH-2:0], 1'b1};
      end else begin
         r_nx_s = shifted_s[WIDTH-1:0];
         q_nx_s = {q_q[WIDTH-2:0], 1'b0};
      end
   end

   // Next-state and next-output logic; a start pulse overrides any state.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sign_a_d    = sign_a_q;
      sign_b_d    = sign_b_q;
      mag_b_d     = mag_b_q;
      r_d         = r_q;
      q_d         = q_q;
      result_d    = result_q;
      remainder_d = remainder_q;
      exc_d       = exc_q;
      rdy_d       = 1'b0;
      if (ctrl_div) begin
         sign_a_d = data_operandA[WIDTH-1];
         sign_b_d = data_operandB[WIDTH-1];
         mag_b_d  = mag_b_s;
         r_d      = {WIDTH{1'b0}};
         cnt_d    = {CNT_W{1'b0}};
         exc_d    = 1'b0;
         if (div_zero_s) begin
            state_d = ST_DONE;
            q_d     = {WIDTH{1'b0}};
         end else if (ovf_s) begin
            state_d = ST_DONE;
            q_d     = MIN_NEG;
         end else begin
            state_d = ST_RUN;
            q_d     = mag_a_s;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_RUN: begin
               r_d   = r_nx_s;
               q_d   = q_nx_s;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_ITER) begin
                  state_d     = ST_DONE;
                  rdy_d       = 1'b1;
                  result_d    = (sign_a_q ^ sign_b_q) ? neg_a_s : q_nx_s;
                  remainder_d = sign_a_q ? neg_r_s : r_nx_s;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_DONE: begin
               // Entering DONE without a ready pulse means an exception start.
               if (rdy_q) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d     = ST_DONE;
                  rdy_d       = 1'b1;
                  exc_d       = 1'b1;
                  result_d    = q_q;
                  remainder_d = r_q;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         sign_a_q    <= 1'b0;
         sign_b_q    <= 1'b0;
         mag_b_q     <= {WIDTH{1'b0}};
         r_q         <= {WIDTH{1'b0}};
         q_q         <= {WIDTH{1'b0}};
         result_q    <= {WIDTH{1'b0}};
         remainder_q <= {WIDTH{1'b0}};
         exc_q       <= 1'b0;
         rdy_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sign_a_q    <= sign_a_d;
         sign_b_q    <= sign_b_d;
         mag_b_q     <= mag_b_d;
         r_q         <= r_d;
         q_q         <= q_d;
         result_q    <= result_d;
         remainder_q <= remainder_d;
         exc_q       <= exc_d;
         rdy_q       <= rdy_d;
      end
   end

   assign data_result    = result_q;
   assign data_remainder = remainder_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;
   assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expectations queued at start, checked by a
// monitor whenever the ready pulse appears.
module tb_div_unit;
   import div_unit_pkg::*;

   logic        clock;
   logic        reset;
   logic        ctrl_div;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [31:0] data_result;
   logic [31:0] data_remainder;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   int total;
   int bad;
   logic [64:0] exp_q[$];
   logic rdy_prev;

   div_unit #(.WIDTH(32)) dut (
      .clock         (clock),
      .reset         (reset),
      .ctrl_div      (ctrl_div),
      .data_operandA (data_operandA),
      .data_operandB (data_operandB),
      .data_result   (data_result),
      .data_remainder(data_remainder),
      .data_exception(data_exception),
      .data_resultRDY(data_resultRDY),
      .busy          (busy)
   );

   always #5 clock = ~clock;

   // Monitor: every ready pulse must match the oldest queued expectation.
   always @(negedge clock) begin
      logic [64:0] e;
      if (!reset && data_resultRDY) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_ready: got q=%h r=%h e=%b, want no ready", data_result, data_remainder, data_exception);
         end else begin
            e = exp_q.pop_front();
            if ({data_exception, data_result, data_remainder} !== e || rdy_prev) begin
               bad++;
               $display("FAIL result: got e=%b q=%h r=%h (ready_prev=%b), want e=%b q=%h r=%h (single pulse)",
                        data_exception, data_result, data_remainder, rdy_prev, e[64], e[63:32], e[31:0]);
            end
         end
      end
      rdy_prev = data_resultRDY;
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic push,
                        input logic [31:0] eq, input logic [31:0] er, input logic ee);
      @(posedge clock);
      #1;
      data_operandA = a;
      data_operandB = b;
      ctrl_div      = 1'b1;
      if (push) exp_q.push_back({ee, eq, er});
      @(posedge clock);
      #1;
      ctrl_div = 1'b0;
   endtask

   task automatic wait_ready(input int lat, input string name);
      bit seen;
      bit busy_ok;
      int k;
      seen    = 1'b0;
      busy_ok = 1'b1;
      k       = -1;
      for (int i = 0; i <= 40 && !seen; i++) begin
         @(negedge clock);
         if (!busy) busy_ok = 1'b0;
         if (data_resultRDY) begin
            seen = 1'b1;
            k    = i;
         end
      end
      total++;
      if (!seen || k != lat) begin
         bad++;
         $display("FAIL latency_%s: got %0d edges, want %0d", name, k, lat);
      end
      total++;
      if (!busy_ok) begin
         bad++;
         $display("FAIL busy_%s: got busy low during operation, want high", name);
      end
   endtask

   task automatic run(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eq, input logic [31:0] er, input logic ee,
                      input int lat, input string name);
      issue(a, b, 1'b1, eq, er, ee);
      wait_ready(lat, name);
   endtask

   initial begin
      logic [31:0] ra, rb, rq, rr;
      clock         = 1'b0;
      reset         = 1'b1;
      ctrl_div      = 1'b0;
      data_operandA = 32'd0;
      data_operandB = 32'd0;
      total         = 0;
      bad           = 0;
      rdy_prev      = 1'b0;
      #12;
      total++;
      if ({data_result, data_remainder, data_exception, data_resultRDY, busy} !== 67'd0) begin
         bad++;
         $display("FAIL reset_state: got q=%h r=%h e=%b rdy=%b busy=%b, want all 0",
                  data_result, data_remainder, data_exception, data_resultRDY, busy);
      end
      @(negedge clock);
      reset = 1'b0;

      run(32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 32, "pos_pos");
      run(32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0, 32, "neg_pos");
      run(32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2,         1'b0, 32, "pos_neg");
      run(32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  1'b0, 32, "neg_neg");
      run(32'd5,         32'd0,         32'd0,         32'd0,         1'b1, 1,  "div_zero");
      run(INT_MIN,       32'hFFFFFFFF,  INT_MIN,       32'd0,         1'b1, 1,  "overflow");
      run(32'd0,         32'd5,         32'd0,         32'd0,         1'b0, 32, "zero_dividend");
      run(32'd7,         32'd100,       32'd0,         32'd7,         1'b0, 32, "small_dividend");
      run(INT_MIN,       32'd2,         32'hC0000000,  32'd0,         1'b0, 32, "min_by_two");
      run(32'hFFFFFFFF,  INT_MIN,       32'd0,         32'hFFFFFFFF,  1'b0, 32, "m1_by_min");
      run(32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,         32'd0,         1'b0, 32, "m1_by_m1");

      // Restart mid-run: only the second operation may report.
      issue(32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0);
      repeat (10) @(negedge clock);
      run(32'd45, 32'd9, 32'd5, 32'd0, 1'b0, 32, "abort_restart");

      // Asynchronous reset mid-run clears everything at once.
      issue(32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0);
      repeat (15) @(negedge clock);
      #2;
      reset = 1'b1;
      #1;
      total++;
      if ({data_result, data_remainder, data_exception, data_resultRDY, busy} !== 67'd0) begin
         bad++;
         $display("FAIL async_reset: got q=%h r=%h e=%b rdy=%b busy=%b, want all 0",
                  data_result, data_remainder, data_exception, data_resultRDY, busy);
      end
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (40) @(negedge clock);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL idle_after_reset: got busy=%b, want 0", busy);
      end
      run(32'd45, 32'd9, 32'd5, 32'd0, 1'b0, 32, "after_reset");

      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i[0]) rb = rb >> 20;
         if (rb == 32'd0) rb = 32'd1;
         if (ra == INT_MIN && rb == 32'hFFFFFFFF) rb = 32'd3;
         rq = $signed(ra) / $signed(rb);
         rr = $signed(ra) % $signed(rb);
         run(ra, rb, rq, rr, 1'b0, 32, "random");
      end

      repeat (3) @(negedge clock);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
